rename_free_list: RTL

Parametrised physical-register free list for the out-of-order rename stage. It supplies one free physical tag per cycle to the register map table and reclaims one tag per cycle from commit. It also keeps per-branch checkpoints of the allocation pointer, so a mispredict can recover every tag allocated after that branch in one cycle. It replaces the flat 64-entry free_list bit array in the core with a circular FIFO.

---
 rtl/rename_free_list.sv | 91 +++++++++
 1 files changed

// File: rtl/rename_free_list.sv
// Physical-register free list for the rename stage: circular FIFO of free tags
// with per-branch checkpoints of the allocation pointer for one-cycle recovery.
module rename_free_list #(
  parameter  int unsigned NUM_PHYS = 64,
  parameter  int unsigned NUM_ARCH = 32,
  parameter  int unsigned NUM_CKPT = 4,
  localparam int unsigned TAG_W    = $clog2(NUM_PHYS),
  localparam int unsigned CK_W     = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
  localparam int unsigned DEPTH    = NUM_PHYS - NUM_ARCH,
  localparam int unsigned PTR_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             rel_valid,
  input  logic [TAG_W-1:0] rel_tag,
  input  logic             ckpt_save,
  input  logic             ckpt_restore,
  input  logic [CK_W-1:0]  ckpt_id,
  output logic [PTR_W-1:0] free_count,
  output logic             overflow_err
);

  localparam int unsigned IDX_W = PTR_W - 1;

  if ((DEPTH == 0) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("rename_free_list: NUM_PHYS-NUM_ARCH must be a power of two");
  end

  logic [TAG_W-1:0] mem  [DEPTH];
  logic [PTR_W-1:0] slot [NUM_CKPT];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W-1:0] head_next, tail_next;
  logic [PTR_W-1:0] count;
  logic             full;
  logic             alloc_fire;
  logic             rel_fire;

  // Outputs depend only on registered pointers and storage.
  assign count       = tail - head;
  assign free_count  = count;
  assign alloc_ready = (count != '0);
  assign alloc_tag   = mem[head[IDX_W-1:0]];
  assign full        = (count == PTR_W'(DEPTH));

  // Restore overrides a same-cycle allocation; a release into a full list is dropped.
  always_comb begin
    alloc_fire = alloc_req && alloc_ready && !ckpt_restore;
    rel_fire   = rel_valid && !full;
    head_next  = head;
    tail_next  = tail;
    if (ckpt_restore) begin
      head_next = slot[ckpt_id];
    end else if (alloc_fire) begin
      head_next = head + PTR_W'(1);
    end
    if (rel_fire) begin
      tail_next = tail + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= TAG_W'(NUM_ARCH + i);
      end
      for (int unsigned k = 0; k < NUM_CKPT; k++) begin
        slot[k] <= '0;
      end
      head         <= '0;
      tail         <= PTR_W'(DEPTH);
      overflow_err <= 1'b0;
    end else begin
      head <= head_next;
      tail <= tail_next;
      if (rel_fire) begin
        mem[tail[IDX_W-1:0]] <= rel_tag;
      end
      // Snapshot includes the branch's own allocation this cycle.
      if (ckpt_save && !ckpt_restore) begin
        slot[ckpt_id] <= head_next;
      end
      if (rel_valid && full) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule
